// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Imported by the array and the responder FSM.
package imem_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/imem_array.sv
// Word array with one synchronous write port and one
// enable-registered read port (read-before-write on collision).
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [XLEN-1:0] rd_data
);

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  // Contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/imem_responder.sv
// Fetch responder: accepts one request, waits WAIT_STATES cycles,
// then presents the addressed word until handshake or flush.
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_error,
  input  logic            load_en,
  input  logic [AW-1:0]   load_addr,
  input  logic [XLEN-1:0] load_data
);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            err_q, err_d;
  logic            accept, sample;
  logic [XLEN-1:0] rd_addr;
  logic [XLEN-1:0] rd_word;

  assign req_ready = (state_q == IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  assign sample    = (state_d == RESP) && (state_q != RESP);

  // With zero wait states the read is taken straight off the bus.
  assign rd_addr = (state_q == IDLE) ? req_addr : addr_q;
  assign err_d   = (rd_addr[1:0] != 2'b00)
                || (rd_addr[XLEN-1:2] >= 30'(DEPTH_WORDS));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      if (sample) err_q <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (flush)              state_d = IDLE;
        else if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        if (flush || resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    resp_valid = (state_q == RESP);
    resp_error = err_q;
    resp_data  = err_q ? NOP_INSN : rd_word;
  end

  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (load_en),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_en   (sample),
    .rd_addr (rd_addr[AW+1:2]),
    .rd_data (rd_word)
  );

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder with three
// wait-state configurations (1, 3, 0) sharing clock, reset and load port.
module tb_imem_responder;
  import imem_pkg::*;

  typedef struct {
    int          k;
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [2:0]  req_ready;
  logic [2:0]  flush = '0;
  logic [2:0]  resp_valid;
  logic [2:0]  resp_ready = '0;
  logic [2:0]  resp_error;
  logic [31:0] req_addr [3];
  logic [31:0] resp_data [3];
  logic        load_en = 1'b0;
  logic [9:0]  load_addr = '0;
  logic [31:0] load_data = '0;

  logic [31:0] model [1024];
  exp_t        sb [$];
  int          hs [$];
  int          cyc = 0;
  int          n_total = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
    imem_responder #(
      .DEPTH_WORDS(1024),
      .WAIT_STATES(WS)
    ) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_addr   (req_addr[g]),
      .flush      (flush[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_data  (resp_data[g]),
      .resp_error (resp_error[g]),
      .load_en    (load_en),
      .load_addr  (load_addr),
      .load_data  (load_data)
    );
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h t=%0t",
               tag, got, want, $time);
    end
  endtask

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
  endfunction

  function automatic exp_t exp_of(input int k,
                                  input logic [31:0] a);
    exp_t        r;
    logic [29:0] w;
    w   = a[31:2];
    r.k = k;
    r.e = (a[1:0] != 2'b00) || (w >= 30'd1024);
    r.d = r.e ? NOP_INSN : model[a[11:2]];
    return r;
  endfunction

  // Handshake monitor: pop and compare on every completed response.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (resp_valid[k] && resp_ready[k] && !flush[k]) begin
        chk("sb_has", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("resp_k", k, e.k);
          chk("resp_data", resp_data[k], e.d);
          chk("resp_err", 32'(resp_error[k]), 32'(e.e));
          hs.push_back(cyc);
        end
      end
    end
  end

  task automatic load(input int idx, input logic [31:0] d);
    @(posedge clk); #1;
    load_en = 1'b1;
    load_addr = 10'(idx);
    load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
    model[idx] = d;
  endtask

  task automatic issue(input int k, input logic [31:0] a,
                       input bit push, output int acc);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    req_valid[k] = 1'b1;
    req_addr[k] = a;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (req_ready[k]) ok = 1'b1;
    end
    chk("accept", 32'(ok), 1);
    acc = cyc;
    if (ok && push) sb.push_back(exp_of(k, a));
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_valid(input int k, output int c);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (resp_valid[k]) ok = 1'b1;
    end
    chk("wait_valid", 32'(resp_valid[k]), 1);
    c = cyc;
  endtask

  task automatic run_fetch(input int k, input logic [31:0] a);
    int c0;
    int w;
    w = ws_of(k);
    resp_ready[k] = 1'b1;
    issue(k, a, 1'b1, c0);
    for (int i = 1; i <= w + 1; i++) begin
      @(negedge clk);
      chk("busy_rdy", 32'(req_ready[k]), 0);
      chk("lat_valid", 32'(resp_valid[k]), 32'(i == w + 1));
    end
    @(negedge clk);
    chk("idle_rdy", 32'(req_ready[k]), 1);
    chk("idle_valid", 32'(resp_valid[k]), 0);
  endtask

  initial begin
    int c0, c1, a0, a1;
    for (int k = 0; k < 3; k++) req_addr[k] = '0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;

    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_rdy", 32'(req_ready[k]), 1);
      chk("rst_valid", 32'(resp_valid[k]), 0);
      chk("rst_data", resp_data[k], 0);
      chk("rst_err", 32'(resp_error[k]), 0);
    end

    // Basic reads, misaligned and out-of-range addresses.
    load(3, 32'hDEAD_BEEF);
    load(1023, 32'hCAFE_F00D);
    run_fetch(0, 32'h0000_000C);
    run_fetch(0, 32'h0000_000E);
    run_fetch(0, 32'h0000_1000);
    run_fetch(0, 32'h0000_0FFC);

    // Stalled response with a load to the held word.
    load(5, 32'h1234_5678);
    resp_ready[0] = 1'b0;
    issue(0, 32'h0000_0014, 1'b1, c0);
    wait_valid(0, c1);
    chk("hold_lat", c1 - c0, 2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      load_en = (i == 1);
      load_addr = 10'd5;
      load_data = 32'hAAAA_5555;
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid[0]), 1);
      chk("hold_data", resp_data[0], 32'h1234_5678);
    end
    model[5] = 32'hAAAA_5555;
    @(posedge clk); #1;
    resp_ready[0] = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_done", 32'(resp_valid[0]), 0);
    run_fetch(0, 32'h0000_0014);

    // Flush while waiting, three wait states.
    resp_ready[1] = 1'b1;
    issue(1, 32'h0000_000C, 1'b0, c0);
    flush[1] = 1'b1;
    @(negedge clk);
    chk("flw_rdy", 32'(req_ready[1]), 0);
    @(posedge clk); #1;
    flush[1] = 1'b0;
    @(negedge clk);
    chk("flw_idle", 32'(req_ready[1]), 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("flw_novalid", 32'(resp_valid[1]), 0);
    end

    // Flush overriding a handshake in RESP.
    resp_ready[1] = 1'b0;
    issue(1, 32'h0000_000C, 1'b0, c0);
    wait_valid(1, c1);
    chk("w3_lat", c1 - c0, 4);
    @(posedge clk); #1;
    flush[1] = 1'b1;
    resp_ready[1] = 1'b1;
    @(posedge clk); #1;
    flush[1] = 1'b0;
    resp_ready[1] = 1'b0;
    @(negedge clk);
    chk("flr_valid", 32'(resp_valid[1]), 0);
    chk("flr_rdy", 32'(req_ready[1]), 1);

    // Flush with a request present in IDLE.
    @(posedge clk); #1;
    flush[1] = 1'b1;
    req_valid[1] = 1'b1;
    req_addr[1] = 32'h0000_000C;
    @(negedge clk);
    chk("fli_rdy", 32'(req_ready[1]), 0);
    @(posedge clk); #1;
    flush[1] = 1'b0;
    req_valid[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("fli_novalid", 32'(resp_valid[1]), 0);
    end
    chk("fli_sb", sb.size(), 0);

    // Zero wait states, back-to-back.
    load(0, 32'h0000_1111);
    load(1, 32'h0000_2222);
    hs.delete();
    resp_ready[2] = 1'b1;
    issue(2, 32'h0000_0000, 1'b1, a0);
    issue(2, 32'h0000_0004, 1'b1, a1);
    repeat (3) @(negedge clk);
    chk("b2b_acc", a1 - a0, 2);
    chk("b2b_cnt", hs.size(), 2);
    if (hs.size() >= 2) chk("b2b_hs", hs[1] - hs[0], 2);

    // Reset while a response is pending.
    resp_ready[0] = 1'b0;
    issue(0, 32'h0000_000C, 1'b0, c0);
    wait_valid(0, c1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(resp_valid[0]), 0);
    chk("arst_data", resp_data[0], 0);
    chk("arst_rdy", 32'(req_ready[0]), 1);
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(negedge clk);
    chk("post_rdy", 32'(req_ready[0]), 1);
    run_fetch(0, 32'h0000_000C);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder at the far end of the fetch-address interface driven by the program counter. It accepts one fetch request at a time, waits a programmable number of wait states, and returns the addressed 32-bit instruction word over a valid/ready response channel. Misaligned or out-of-range addresses are flagged. Requests can be cancelled by a fetch flush on a taken branch. A side load port fills the array before or between runs.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array; power of two, at least 4.
- WAIT_STATES, 1: extra cycles between request acceptance and response; 0 to 15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_addr  in  32  byte address, the PC value.
- flush  in  1  cancel any in-flight or pending fetch (taken branch).
- resp_valid  out  1  response word available.
- resp_ready  in  1  fetch stage consumes the response.
- resp_data  out  32  instruction word.
- resp_error  out  1  request was misaligned or out of range.
- load_en  in  1  write one word into the array.
- load_addr  in  $clog2(DEPTH_WORDS)  word index for the load.
- load_data  in  32  word to write.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- IDLE:
  - req_ready = !flush.
  - A request is accepted on the cycle where req_valid && req_ready.
  - On acceptance, capture req_addr and set the wait counter to WAIT_STATES.
  - If WAIT_STATES == 0, go to RESP; otherwise go to WAIT.
- WAIT:
  - req_ready = 0.
  - The counter decrements each cycle; on the cycle it reaches 1, go to RESP.
- RESP:
  - resp_valid = 1; resp_data and resp_error are stable.
  - When resp_ready is high, go to IDLE.
  - No new request is accepted in the same cycle as the handshake.
- Word index = addr[31:2].
  - resp_error = (addr[1:0] != 0) || (addr[31:2] >= DEPTH_WORDS).
  - On error, resp_data = 32'h0000_0013 (NOP).
- The read is sampled on the clock edge that enters RESP. The sampled word is held for the whole time the FSM stays in RESP.
- Load port:
  - A write occurs on any cycle with load_en, in every state.
  - A load to the word being sampled on that same edge returns the old contents.
  - A load to a word that is held in RESP does not alter resp_data.
- Flush:
  - In WAIT or RESP, go to IDLE on the next edge; no response is produced.
  - In IDLE, req_ready is forced low, so nothing is accepted that cycle.
  - Flush overrides resp_ready in the same cycle; the result is still IDLE with no double count.

## Timing
- Reset values:
  - state IDLE, counter 0, captured address 0.
  - resp_valid 0, resp_data 0, resp_error 0.
  - req_ready is 1 after reset (combinational from IDLE and !flush).
- Array contents are not reset.
- Latency from acceptance edge to resp_valid high is WAIT_STATES + 1 cycles.
- Minimum spacing between accepted requests is WAIT_STATES + 2 cycles when resp_ready is held high.
- Reset asserted mid-operation returns everything to the reset values immediately. A pending response is lost.
- resp_valid does not drop without a handshake, flush or reset.

## Structure
- Package imem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - localparam NOP_INSN = 32'h0000_0013;
  - localparam XLEN = 32.
- Sub-module imem_array:
  - one synchronous write port and one read port;
  - the read is registered under an enable driven by the FSM.

## Test plan
- WAIT_STATES=1, array word 3 = 32'hDEAD_BEEF; request 0x0C with resp_ready=1 -> req_ready low for 2 cycles; resp_valid high 2 cycles after acceptance with data DEADBEEF, error 0.
- Request 0x0E -> resp_error=1, resp_data=00000013. With DEPTH_WORDS=1024, request 0x1000 -> resp_error=1.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_data stable throughout; a load to the same word meanwhile does not change resp_data.
- Flush during WAIT with WAIT_STATES=3 -> no resp_valid pulse; req_ready high the following cycle. Flush with req_valid in IDLE -> not accepted.
- WAIT_STATES=0, back-to-back requests 0x0, 0x4 with resp_ready=1 -> responses 2 cycles apart, in order.
- Assert reset_n=0 while in RESP -> resp_valid 0 asynchronously; after release, req_ready=1 and the next request works normally.
